// File: rtl/fib_sweep_ctrl.sv
// Sweep sequencer and in-circuit checker for the Fibonacci-membership detector:
// drives x = 0..2^N-1, compares the returned flag against a generated sequence.
module fib_sweep_ctrl #(
    parameter int N   = 4,
    parameter int LAT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic         is_fib,
    output logic [N-1:0] x,
    output logic         x_valid,
    output logic         busy,
    output logic         done,
    output logic [N:0]   fib_count,
    output logic [N:0]   err_count,
    output logic [N-1:0] first_err_x,
    output logic         err_flag
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int            DW         = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(LAT - 1);
    localparam logic [N-1:0]  X_LAST     = {N{1'b1}};
    localparam logic [N+1:0]  F_INIT     = {{(N+1){1'b0}}, 1'b1};
    localparam logic [N+1:0]  G_INIT     = {{N{1'b0}}, 2'b10};

    state_t         state_q, state_d;
    logic [N-1:0]   x_q, x_d;
    logic           x_valid_q, busy_q, done_q;
    logic [DW-1:0]  drain_q, drain_d;
    logic [N+1:0]   f_q, f_d, g_q, g_d;
    logic [N:0]     fib_count_q, fib_count_d, err_count_q, err_count_d;
    logic [N-1:0]   first_err_x_q, first_err_x_d;
    logic           err_flag_q, err_flag_d;
    logic           live_hit, live_exp, kill;
    logic           smp_v, smp_e;
    logic [N-1:0]   smp_x;

    assign live_hit = ({2'b00, x_q} == f_q);
    assign live_exp = (x_q == {N{1'b0}}) | live_hit;

    // Sample point: either the live stimulus or the tail of the LAT-deep delay line.
    if (LAT == 0) begin : g_comb
        assign smp_v = x_valid_q;
        assign smp_x = x_q;
        assign smp_e = live_exp;
    end else begin : g_pipe
        logic [LAT-1:0] pv_q;
        logic [LAT-1:0] pe_q;
        logic [N-1:0]   px_q [LAT];

        // Delay line carrying valid, x and expected flag alongside the detector.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pv_q <= '0;
                pe_q <= '0;
                for (int i = 0; i < LAT; i++) px_q[i] <= '0;
            end else begin
                for (int i = LAT - 1; i > 0; i--) begin
                    pv_q[i] <= pv_q[i-1];
                    pe_q[i] <= pe_q[i-1];
                    px_q[i] <= px_q[i-1];
                end
                pv_q[0] <= x_valid_q;
                pe_q[0] <= live_exp;
                px_q[0] <= x_q;
                if (kill) begin
                    pv_q <= '0;
                end
            end
        end

        assign smp_v = pv_q[LAT-1];
        assign smp_x = px_q[LAT-1];
        assign smp_e = pe_q[LAT-1];
    end

    // Next-state, generator and result accumulation.
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        drain_d       = drain_q;
        f_d           = f_q;
        g_d           = g_q;
        fib_count_d   = fib_count_q;
        err_count_d   = err_count_q;
        first_err_x_d = first_err_x_q;
        err_flag_d    = err_flag_q;
        kill          = 1'b0;

        if (smp_v) begin
            fib_count_d = fib_count_q + {{N{1'b0}}, is_fib};
            if (is_fib != smp_e) begin
                err_count_d = err_count_q + {{N{1'b0}}, 1'b1};
                if (!err_flag_q) begin
                    first_err_x_d = smp_x;
                    err_flag_d    = 1'b1;
                end else begin
                    first_err_x_d = first_err_x_q;
                end
            end else begin
                err_count_d = err_count_q;
            end
        end else begin
            fib_count_d = fib_count_q;
        end

        // f runs ahead through the sequence only when the sweep reaches it.
        if (x_valid_q && live_hit) begin
            f_d = g_q;
            g_d = f_q + g_q;
        end else begin
            f_d = f_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d       = S_RUN;
                    x_d           = {N{1'b0}};
                    f_d           = F_INIT;
                    g_d           = G_INIT;
                    fib_count_d   = {(N+1){1'b0}};
                    err_count_d   = {(N+1){1'b0}};
                    first_err_x_d = {N{1'b0}};
                    err_flag_d    = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    kill    = 1'b1;
                end else begin
                    x_d     = x_q + {{(N-1){1'b0}}, 1'b1};
                    drain_d = {DW{1'b0}};
                    if (x_q == X_LAST) begin
                        state_d = (LAT > 0) ? S_DRAIN : S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    kill    = 1'b1;
                end else if (drain_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + {{(DW-1){1'b0}}, 1'b1};
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, generator and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            x_q           <= '0;
            x_valid_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            drain_q       <= '0;
            f_q           <= F_INIT;
            g_q           <= G_INIT;
            fib_count_q   <= '0;
            err_count_q   <= '0;
            first_err_x_q <= '0;
            err_flag_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            x_valid_q     <= (state_d == S_RUN);
            busy_q        <= (state_d == S_RUN) || (state_d == S_DRAIN);
            done_q        <= (state_d == S_DONE);
            drain_q       <= drain_d;
            f_q           <= f_d;
            g_q           <= g_d;
            fib_count_q   <= fib_count_d;
            err_count_q   <= err_count_d;
            first_err_x_q <= first_err_x_d;
            err_flag_q    <= err_flag_d;
        end
    end

    assign x           = x_q;
    assign x_valid     = x_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign fib_count   = fib_count_q;
    assign err_count   = err_count_q;
    assign first_err_x = first_err_x_q;
    assign err_flag    = err_flag_q;

endmodule

// File: tb/tb_fib_sweep_ctrl.sv
// Bench for fib_sweep_ctrl: a LAT=0 instance with a fault-injectable detector
// model and a LAT=2 instance fed through a selectable-depth delay line.
module tb_fib_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start0, abort0, is_fib0;
    logic       start2, abort2, is_fib2;
    logic [3:0] x0, x2, fe0, fe2;
    logic       xv0, xv2, busy0, busy2, done0, done2, ef0, ef2;
    logic [4:0] fc0, fc2, ec0, ec2;

    int         vec_cnt = 0;
    int         miscmp  = 0;
    int         mode    = 0;
    logic       dly2    = 1'b1;
    logic       d1 = 1'b0, d2 = 1'b0;
    logic [3:0] exp_q[$];

    fib_sweep_ctrl #(.N(4), .LAT(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .is_fib(is_fib0),
        .x(x0), .x_valid(xv0), .busy(busy0), .done(done0),
        .fib_count(fc0), .err_count(ec0), .first_err_x(fe0), .err_flag(ef0)
    );

    fib_sweep_ctrl #(.N(4), .LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2), .is_fib(is_fib2),
        .x(x2), .x_valid(xv2), .busy(busy2), .done(done2),
        .fib_count(fc2), .err_count(ec2), .first_err_x(fe2), .err_flag(ef2)
    );

    function automatic logic ref_fib(input logic [3:0] v);
        return (v == 4'd0) || (v == 4'd1) || (v == 4'd2) || (v == 4'd3) ||
               (v == 4'd5) || (v == 4'd8) || (v == 4'd13);
    endfunction

    always_comb begin
        case (mode)
            0:       is_fib0 = ref_fib(x0);
            1:       is_fib0 = ref_fib(x0) ^ ((x0 == 4'd4) || (x0 == 4'd9));
            2:       is_fib0 = 1'b1;
            default: is_fib0 = 1'b0;
        endcase
    end

    always @(posedge clk) begin
        d1 <= ref_fib(x2);
        d2 <= d1;
    end
    assign is_fib2 = dly2 ? d2 : d1;

    task automatic do_sweep(input int dut, output int cyc);
        logic [3:0] ex;
        logic [3:0] xa;
        @(negedge clk);
        if (dut == 0) start0 = 1'b1; else start2 = 1'b1;
        for (int i = 0; i < 16; i++) exp_q.push_back(4'(i));
        @(negedge clk);
        start0 = 1'b0;
        start2 = 1'b0;
        cyc = -1;
        for (int c = 0; c < 40; c++) begin
            if (((dut == 0) ? done0 : done2) === 1'b1) begin
                cyc = c;
                break;
            end
            if (((dut == 0) ? xv0 : xv2) === 1'b1) begin
                xa = (dut == 0) ? x0 : x2;
                ex = 4'hx;
                if (exp_q.size() > 0) ex = exp_q.pop_front();
                vec_cnt++;
                if (xa !== ex) begin
                    miscmp++;
                    $display("FAIL sweep_x: got %0d expected %0d", xa, ex);
                end
            end
            @(negedge clk);
        end
        vec_cnt++;
        if (cyc < 0) begin
            miscmp++;
            $display("FAIL done_timeout: got no done, expected done within 40 cycles");
        end
        vec_cnt++;
        if (exp_q.size() != 0) begin
            miscmp++;
            $display("FAIL sweep_len: got %0d x values missing, expected 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; start0 = 1'b0; abort0 = 1'b0; start2 = 1'b0; abort2 = 1'b0;
        repeat (2) @(negedge clk);
        vec_cnt++;
        if ({x0, xv0, busy0, done0, fc0, ec0, fe0, ef0} !== 23'd0) begin
            miscmp++;
            $display("FAIL reset_dut0: got %h expected 0", {x0, xv0, busy0, done0, fc0, ec0, fe0, ef0});
        end
        vec_cnt++;
        if ({x2, xv2, busy2, done2, fc2, ec2, fe2, ef2} !== 23'd0) begin
            miscmp++;
            $display("FAIL reset_dut2: got %h expected 0", {x2, xv2, busy2, done2, fc2, ec2, fe2, ef2});
        end
        rst = 1'b0;
    endtask

    task automatic test_sweep(input int m, input logic [4:0] efc, input logic [4:0] eec,
                              input logic [3:0] efe, input logic eef);
        int cyc;
        mode = m;
        do_sweep(0, cyc);
        vec_cnt++;
        if (cyc !== 16) begin miscmp++; $display("FAIL m%0d_latency: got %0d expected 16", m, cyc); end
        vec_cnt++;
        if (fc0 !== efc) begin miscmp++; $display("FAIL m%0d_fib_count: got %0d expected %0d", m, fc0, efc); end
        vec_cnt++;
        if (ec0 !== eec) begin miscmp++; $display("FAIL m%0d_err_count: got %0d expected %0d", m, ec0, eec); end
        vec_cnt++;
        if (fe0 !== efe) begin miscmp++; $display("FAIL m%0d_first_err_x: got %0d expected %0d", m, fe0, efe); end
        vec_cnt++;
        if (ef0 !== eef) begin miscmp++; $display("FAIL m%0d_err_flag: got %0d expected %0d", m, ef0, eef); end
        vec_cnt++;
        if (busy0 !== 1'b0) begin miscmp++; $display("FAIL m%0d_busy_at_done: got %0d expected 0", m, busy0); end
    endtask

    task automatic test_lat2();
        int cyc;
        dly2 = 1'b1;
        do_sweep(2, cyc);
        vec_cnt++;
        if (cyc !== 18) begin miscmp++; $display("FAIL lat2_latency: got %0d expected 18", cyc); end
        vec_cnt++;
        if ({fc2, ec2, fe2, ef2} !== {5'd7, 5'd0, 4'd0, 1'b0}) begin
            miscmp++;
            $display("FAIL lat2_results: got fib=%0d err=%0d fe=%0d flag=%0d expected 7 0 0 0", fc2, ec2, fe2, ef2);
        end
        dly2 = 1'b0;
        do_sweep(2, cyc);
        vec_cnt++;
        if (ec2 === 5'd0 || ef2 !== 1'b1) begin
            miscmp++;
            $display("FAIL lat2_short_delay: got err=%0d flag=%0d expected nonzero err, flag 1", ec2, ef2);
        end
        dly2 = 1'b1;
    endtask

    task automatic test_back_to_back();
        int cyc;
        mode = 0;
        do_sweep(0, cyc);
        do_sweep(0, cyc);
        vec_cnt++;
        if (cyc !== 16 || fc0 !== 5'd7 || ec0 !== 5'd0) begin
            miscmp++;
            $display("FAIL back_to_back: got cyc=%0d fib=%0d err=%0d expected 16 7 0", cyc, fc0, ec0);
        end
    endtask

    task automatic test_start_abort();
        logic seen_done;
        mode = 0;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        repeat (5) @(negedge clk);
        vec_cnt++;
        if (x0 !== 4'd5) begin miscmp++; $display("FAIL at_x5: got %0d expected 5", x0); end
        start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        vec_cnt++;
        if (x0 !== 4'd6 || busy0 !== 1'b1) begin
            miscmp++;
            $display("FAIL start_ignored: got x=%0d busy=%0d expected 6 1", x0, busy0);
        end
        repeat (2) @(negedge clk);
        abort0 = 1'b1;
        @(negedge clk); abort0 = 1'b0;
        vec_cnt++;
        if ({busy0, xv0, done0} !== 3'b000 || fc0 !== 5'd6) begin
            miscmp++;
            $display("FAIL abort: got busy=%0d xv=%0d done=%0d fib=%0d expected 0 0 0 6", busy0, xv0, done0, fc0);
        end
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done0 === 1'b1) seen_done = 1'b1;
        end
        vec_cnt++;
        if (seen_done !== 1'b0 || fc0 !== 5'd6) begin
            miscmp++;
            $display("FAIL abort_hold: got done_seen=%0d fib=%0d expected 0 6", seen_done, fc0);
        end
    endtask

    task automatic test_rst_mid();
        int cyc;
        mode = 0;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        repeat (10) @(negedge clk);
        vec_cnt++;
        if (x0 !== 4'd10 || fc0 !== 5'd6) begin
            miscmp++;
            $display("FAIL pre_rst: got x=%0d fib=%0d expected 10 6", x0, fc0);
        end
        #2 rst = 1'b1;
        #1;
        vec_cnt++;
        if ({x0, xv0, busy0, done0, fc0, ec0, fe0, ef0} !== 23'd0) begin
            miscmp++;
            $display("FAIL async_rst: got %h expected 0", {x0, xv0, busy0, done0, fc0, ec0, fe0, ef0});
        end
        @(negedge clk); rst = 1'b0;
        do_sweep(0, cyc);
        vec_cnt++;
        if (cyc !== 16 || fc0 !== 5'd7 || ec0 !== 5'd0) begin
            miscmp++;
            $display("FAIL post_rst_sweep: got cyc=%0d fib=%0d err=%0d expected 16 7 0", cyc, fc0, ec0);
        end
    endtask

    initial begin
        test_reset();
        test_sweep(0, 5'd7,  5'd0, 4'd0, 1'b0);
        test_sweep(1, 5'd9,  5'd2, 4'd4, 1'b1);
        test_sweep(2, 5'd16, 5'd9, 4'd4, 1'b1);
        test_sweep(3, 5'd0,  5'd7, 4'd0, 1'b1);
        test_lat2();
        test_back_to_back();
        test_start_abort();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
